// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the two-port ALU arbiter.
//   arb_state_e : sequencer states (ARB_IDLE, ARB_EXEC, ARB_RESP)
//   FLG_*       : bit positions of the ALU flags inside rs_flg {az,an,ac,av}
//   HC_W, SC_W  : opcode field widths, identical to the ALU's ps_alu_hc/sc
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam int FLG_AZ = 3;
  localparam int FLG_AN = 2;
  localparam int FLG_AC = 1;
  localparam int FLG_AV = 0;
  localparam int FLG_W  = 4;

  localparam int HC_W = 2;
  localparam int SC_W = 3;

endpackage

// File: rtl/alu_arb_if.sv
// alu_arb_if: bundle of every non-clock/reset signal around the arbiter.
//   rq0_* / rq1_* : request channels (valid/ready, opcode fields, operands, lock)
//   ps_alu_* / xb_dt* : issue bus towards the ALU
//   alu_xb_dt / alu_ps_a* : ALU result word and flags
//   rs_* : response channel (valid/ready, id, data, flags)
// Modports:
//   slave  - the arbiter itself
//   master - everything around it (requesters, ALU, response consumer)
interface alu_arb_if #(
  parameter int DATA_WIDTH = 16
);
  import alu_arb_pkg::*;

  logic                  rq0_vld,  rq1_vld;
  logic                  rq0_rdy,  rq1_rdy;
  logic                  rq0_log,  rq1_log;
  logic [HC_W-1:0]       rq0_hc,   rq1_hc;
  logic [SC_W-1:0]       rq0_sc,   rq1_sc;
  logic                  rq0_sat,  rq1_sat;
  logic                  rq0_ci,   rq1_ci;
  logic [DATA_WIDTH-1:0] rq0_dtx,  rq1_dtx;
  logic [DATA_WIDTH-1:0] rq0_dty,  rq1_dty;
  logic                  rq0_lock, rq1_lock;

  logic                  ps_alu_en;
  logic                  ps_alu_log;
  logic [HC_W-1:0]       ps_alu_hc;
  logic [SC_W-1:0]       ps_alu_sc;
  logic                  ps_alu_sat;
  logic                  ps_alu_ci;
  logic [DATA_WIDTH-1:0] xb_dtx, xb_dty;

  logic [DATA_WIDTH-1:0] alu_xb_dt;
  logic                  alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av;

  logic                  rs_vld;
  logic                  rs_rdy;
  logic                  rs_id;
  logic [DATA_WIDTH-1:0] rs_dt;
  logic [FLG_W-1:0]      rs_flg;

  modport slave (
    input  rq0_vld, rq1_vld, rq0_log, rq1_log, rq0_hc, rq1_hc,
           rq0_sc, rq1_sc, rq0_sat, rq1_sat, rq0_ci, rq1_ci,
           rq0_dtx, rq1_dtx, rq0_dty, rq1_dty, rq0_lock, rq1_lock,
           alu_xb_dt, alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, rs_rdy,
    output rq0_rdy, rq1_rdy,
           ps_alu_en, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat, ps_alu_ci,
           xb_dtx, xb_dty,
           rs_vld, rs_id, rs_dt, rs_flg
  );

  modport master (
    output rq0_vld, rq1_vld, rq0_log, rq1_log, rq0_hc, rq1_hc,
           rq0_sc, rq1_sc, rq0_sat, rq1_sat, rq0_ci, rq1_ci,
           rq0_dtx, rq1_dtx, rq0_dty, rq1_dty, rq0_lock, rq1_lock,
           alu_xb_dt, alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, rs_rdy,
    input  rq0_rdy, rq1_rdy,
           ps_alu_en, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat, ps_alu_ci,
           xb_dtx, xb_dty,
           rs_vld, rs_id, rs_dt, rs_flg
  );

endinterface

// File: rtl/alu_arb_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a preference pointer.
//   clk, reset : clock, asynchronous active-low reset (pointer -> 0)
//   en         : an issue opportunity exists this cycle
//   req[1:0]   : request valids
//   lock       : lock bit of the requester being granted this cycle
//   gnt[1:0]   : one-hot (or zero) grant, combinational
//   gnt_id     : index of the granted requester (meaningful when |gnt)
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       lock,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic rr_ptr;

  always_comb begin
    gnt    = 2'b00;
    gnt_id = rr_ptr;
    if (en) begin
      if (req[rr_ptr]) begin
        gnt[rr_ptr] = 1'b1;
        gnt_id      = rr_ptr;
      end else if (req[~rr_ptr]) begin
        gnt[~rr_ptr] = 1'b1;
        gnt_id       = ~rr_ptr;
      end
    end
  end

  // A locked grant parks the pointer on the winner so it is preferred next
  // time, even if it only won because the other port was idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 1'b0;
    end else if (|gnt) begin
      rr_ptr <= lock ? gnt_id : ~gnt_id;
    end
  end

endmodule

// File: rtl/alu_arb.sv
// alu_arb: two-port arbiter/sequencer in front of the shared ALU.
// Grants rq0/rq1 round-robin, issues the op to the ALU, captures result and
// flags one cycle later and presents them on the rs_* channel with backpressure.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : alu_arb_if.slave (request, ALU and response channels)
// Build option: ALU_ARB_LOCK_EN honours rqN_lock (grant hold for carry chains);
// without it the lock inputs are ignored and arbitration is strict round robin.
//
// state    | meaning
// ARB_IDLE | nothing in flight, may issue
// ARB_EXEC | ALU evaluating, result/flags captured at cycle end
// ARB_RESP | rs_vld high; on rs_rdy may issue the next op in the same cycle
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  alu_arb_if.slave   bus
);

  arb_state_e            state_q, state_d;
  logic                  ci_q;
  logic                  id_q;
  logic                  rs_id_q;
  logic [DATA_WIDTH-1:0] rs_dt_q;
  logic [FLG_W-1:0]      rs_flg_q;

  logic                  issue_ok;
  logic                  issue;
  logic [1:0]            gnt;
  logic                  gnt_id;
  logic                  lock_sel;

  // Held in reset, no grant may be shown even though the state reads IDLE.
  assign issue_ok = reset &&
                    ((state_q == ARB_IDLE) || ((state_q == ARB_RESP) && bus.rs_rdy));

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .en     (issue_ok),
    .req    ({bus.rq1_vld, bus.rq0_vld}),
    .lock   (lock_sel),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

`ifdef ALU_ARB_LOCK_EN
  assign lock_sel = gnt_id ? bus.rq1_lock : bus.rq0_lock;
`else
  logic unused_lock;
  assign unused_lock = bus.rq0_lock ^ bus.rq1_lock;
  assign lock_sel    = 1'b0;
`endif

  assign issue       = |gnt;
  assign bus.rq0_rdy = gnt[0];
  assign bus.rq1_rdy = gnt[1];

  // Issue mux. Carry-in stays on ci_q after issue because the ALU reads it
  // combinationally while evaluating in EXEC.
  always_comb begin
    bus.ps_alu_en  = 1'b0;
    bus.ps_alu_log = 1'b0;
    bus.ps_alu_hc  = '0;
    bus.ps_alu_sc  = '0;
    bus.ps_alu_sat = 1'b0;
    bus.ps_alu_ci  = ci_q;
    bus.xb_dtx     = '0;
    bus.xb_dty     = '0;
    if (issue) begin
      bus.ps_alu_en = 1'b1;
      if (gnt_id) begin
        bus.ps_alu_log = bus.rq1_log;
        bus.ps_alu_hc  = bus.rq1_hc;
        bus.ps_alu_sc  = bus.rq1_sc;
        bus.ps_alu_sat = bus.rq1_sat;
        bus.ps_alu_ci  = bus.rq1_ci;
        bus.xb_dtx     = bus.rq1_dtx;
        bus.xb_dty     = bus.rq1_dty;
      end else begin
        bus.ps_alu_log = bus.rq0_log;
        bus.ps_alu_hc  = bus.rq0_hc;
        bus.ps_alu_sc  = bus.rq0_sc;
        bus.ps_alu_sat = bus.rq0_sat;
        bus.ps_alu_ci  = bus.rq0_ci;
        bus.xb_dtx     = bus.rq0_dtx;
        bus.xb_dty     = bus.rq0_dty;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (issue) state_d = ARB_EXEC;
      ARB_EXEC: state_d = ARB_RESP;
      ARB_RESP: begin
        if (bus.rs_rdy) state_d = issue ? ARB_EXEC : ARB_IDLE;
      end
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      ci_q     <= 1'b0;
      id_q     <= 1'b0;
      rs_id_q  <= 1'b0;
      rs_dt_q  <= '0;
      rs_flg_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        ci_q <= bus.ps_alu_ci;
        id_q <= gnt_id;
      end
      if (state_q == ARB_EXEC) begin
        rs_id_q          <= id_q;
        rs_dt_q          <= bus.alu_xb_dt;
        rs_flg_q[FLG_AZ] <= bus.alu_ps_az;
        rs_flg_q[FLG_AN] <= bus.alu_ps_an;
        rs_flg_q[FLG_AC] <= bus.alu_ps_ac;
        rs_flg_q[FLG_AV] <= bus.alu_ps_av;
      end
    end
  end

  assign bus.rs_vld = (state_q == ARB_RESP);
  assign bus.rs_id  = rs_id_q;
  assign bus.rs_dt  = rs_dt_q;
  assign bus.rs_flg = rs_flg_q;

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: directed testbench for alu_arb with a small behavioural ALU
// (add/sub/add-with-carry, sticky saturation) hanging off the issue bus.
// Build with ALU_ARB_LOCK_EN defined to exercise the grant-hold option.
module tb_alu_arb;
  import alu_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_arb_if #(.DATA_WIDTH(16)) bus ();

  alu_arb #(.DATA_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural ALU: operands load on issue, result is combinational after.
  logic [15:0] m_x = '0, m_y = '0, m_res;
  logic [2:0]  m_sc = '0;
  logic        m_sat = 1'b0;
  logic [16:0] m_sum;
  logic        m_ov;

  always @(posedge clk) begin
    if (bus.ps_alu_en) begin
      m_x   <= bus.xb_dtx;
      m_y   <= bus.xb_dty;
      m_sc  <= bus.ps_alu_sc;
      m_sat <= bus.ps_alu_sat;
    end
  end

  always_comb begin
    m_sum = {1'b0, m_x} + {1'b0, m_y};
    m_ov  = 1'b0;
    case (m_sc)
      3'b001:  m_sum = {1'b0, m_x} - {1'b0, m_y};
      3'b010:  m_sum = {1'b0, m_x} + {1'b0, m_y} + {16'd0, bus.ps_alu_ci};
      default: m_sum = {1'b0, m_x} + {1'b0, m_y};
    endcase
    if (m_sc == 3'b001) m_ov = (m_x[15] != m_y[15]) && (m_sum[15] != m_x[15]);
    else                m_ov = (m_x[15] == m_y[15]) && (m_sum[15] != m_x[15]);
    m_res = m_sum[15:0];
    if (m_ov && m_sat) m_res = m_x[15] ? 16'h8000 : 16'h7FFF;
  end

  assign bus.alu_xb_dt = m_res;
  assign bus.alu_ps_az = (m_res == 16'h0000);
  assign bus.alu_ps_an = m_res[15];
  assign bus.alu_ps_ac = m_sum[16];
  assign bus.alu_ps_av = m_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rq(input int id, input logic vld, input logic [2:0] sc,
                          input logic sat, input logic ci,
                          input logic [15:0] x, input logic [15:0] y);
    if (id == 0) begin
      bus.rq0_vld = vld; bus.rq0_log = 1'b0; bus.rq0_hc = '0; bus.rq0_sc = sc;
      bus.rq0_sat = sat; bus.rq0_ci = ci; bus.rq0_dtx = x; bus.rq0_dty = y;
    end else begin
      bus.rq1_vld = vld; bus.rq1_log = 1'b0; bus.rq1_hc = '0; bus.rq1_sc = sc;
      bus.rq1_sat = sat; bus.rq1_ci = ci; bus.rq1_dtx = x; bus.rq1_dty = y;
    end
  endtask

  // Single op from IDLE with rs_rdy high; entered and left at posedge+1.
  task automatic do_op(input string tag, input int id, input logic [2:0] sc,
                       input logic sat, input logic ci,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] exp_dt, input logic [3:0] exp_flg);
    drive_rq(id, 1'b1, sc, sat, ci, x, y);
    #2;
    chk({tag, " grant"},  (id == 0) ? bus.rq0_rdy : bus.rq1_rdy, 1);
    chk({tag, " other"},  (id == 0) ? bus.rq1_rdy : bus.rq0_rdy, 0);
    chk({tag, " en"},     bus.ps_alu_en, 1);
    chk({tag, " sat"},    bus.ps_alu_sat, sat);
    chk({tag, " dtx"},    bus.xb_dtx, x);
    @(posedge clk); #1;
    drive_rq(id, 1'b0, sc, sat, ci, x, y);
    #2;
    chk({tag, " exec en"},  bus.ps_alu_en, 0);
    chk({tag, " exec vld"}, bus.rs_vld, 0);
    chk({tag, " exec ci"},  bus.ps_alu_ci, ci);
    @(posedge clk); #3;
    chk({tag, " rs_vld"}, bus.rs_vld, 1);
    chk({tag, " rs_dt"},  bus.rs_dt, exp_dt);
    chk({tag, " rs_flg"}, bus.rs_flg, exp_flg);
    chk({tag, " rs_id"},  bus.rs_id, id);
    @(posedge clk); #1;
  endtask

  initial begin
    drive_rq(0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive_rq(1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    bus.rq0_lock = 1'b0;
    bus.rq1_lock = 1'b0;
    bus.rs_rdy   = 1'b1;

    // Reset state, with a request pending that must not be granted.
    repeat (2) @(posedge clk);
    #1;
    bus.rq0_vld = 1'b1;
    #2;
    chk("rst rq0_rdy", bus.rq0_rdy, 0);
    chk("rst rs_vld",  bus.rs_vld, 0);
    chk("rst rs_dt",   bus.rs_dt, 0);
    chk("rst rs_flg",  bus.rs_flg, 0);
    chk("rst rs_id",   bus.rs_id, 0);
    chk("rst en",      bus.ps_alu_en, 0);
    bus.rq0_vld = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    do_op("add",    0, 3'b000, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0007, 4'b0000);
    do_op("sub",    1, 3'b001, 1'b0, 1'b0, 16'h0004, 16'h0004, 16'h0000, 4'b1000);
    do_op("satadd", 0, 3'b000, 1'b1, 1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b0001);
    do_op("wrapadd",0, 3'b000, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    do_op("adc",    1, 3'b010, 1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0003, 4'b0000);

    // Both valid, rs_rdy high: grants 0,1,0,1 every other cycle (ptr at 0).
    drive_rq(0, 1'b1, 3'b000, 1'b0, 1'b0, 16'h0001, 16'h0001);
    drive_rq(1, 1'b1, 3'b000, 1'b0, 1'b0, 16'h8000, 16'h0010);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("alt rq0_rdy", bus.rq0_rdy, (i % 2) == 0);
      chk("alt rq1_rdy", bus.rq1_rdy, (i % 2) == 1);
      if (i > 0) begin
        chk("alt rs_id", bus.rs_id, ((i - 1) % 2) == 1);
        chk("alt rs_dt", bus.rs_dt, (((i - 1) % 2) == 1) ? 16'h8010 : 16'h0002);
      end
      @(posedge clk); #3;
      chk("alt exec rdy", {bus.rq1_rdy, bus.rq0_rdy}, 2'b00);
      @(posedge clk); #1;
    end

    // Backpressure in RESP holding the rq1 result.
    bus.rs_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp rs_vld", bus.rs_vld, 1);
      chk("bp rs_dt",  bus.rs_dt, 16'h8010);
      chk("bp rs_id",  bus.rs_id, 1);
      chk("bp rs_flg", bus.rs_flg, 4'b0100);
      chk("bp rdy",    {bus.rq1_rdy, bus.rq0_rdy}, 2'b00);
      @(posedge clk); #1;
    end
    bus.rs_rdy = 1'b1;
    #2;
    chk("bp rel vld", bus.rs_vld, 1);
    chk("bp rel rdy", {bus.rq1_rdy, bus.rq0_rdy}, 2'b01);
    @(posedge clk); #1;

    // Reset during EXEC of the rq0 op; pointer had moved to rq1.
    reset = 1'b0;
    #2;
    chk("rx rs_vld", bus.rs_vld, 0);
    chk("rx rs_dt",  bus.rs_dt, 0);
    chk("rx rs_flg", bus.rs_flg, 0);
    chk("rx rs_id",  bus.rs_id, 0);
    chk("rx en",     bus.ps_alu_en, 0);
    chk("rx ci",     bus.ps_alu_ci, 0);
    chk("rx rdy",    {bus.rq1_rdy, bus.rq0_rdy}, 2'b00);
    @(posedge clk); #3;
    chk("rx hold vld", bus.rs_vld, 0);
    chk("rx hold rdy", {bus.rq1_rdy, bus.rq0_rdy}, 2'b00);
    @(posedge clk); #1;

    // Release with both valid: rq0 wins from the reset pointer, with lock set.
    reset = 1'b1;
    bus.rq0_lock = 1'b1;
    #2;
    chk("post rdy", {bus.rq1_rdy, bus.rq0_rdy}, 2'b01);
    @(posedge clk); #3;
    chk("post exec vld", bus.rs_vld, 0);
    @(posedge clk); #3;
    chk("post rs_id", bus.rs_id, 0);
    chk("post rs_dt", bus.rs_dt, 16'h0002);
`ifdef ALU_ARB_LOCK_EN
    chk("lock rdy", {bus.rq1_rdy, bus.rq0_rdy}, 2'b01);
`else
    chk("nolock rdy", {bus.rq1_rdy, bus.rq0_rdy}, 2'b10);
`endif
    @(posedge clk); #1;
    bus.rq0_vld  = 1'b0;
    bus.rq1_vld  = 1'b0;
    bus.rq0_lock = 1'b0;
    @(posedge clk); #3;
    chk("last rs_vld", bus.rs_vld, 1);
`ifdef ALU_ARB_LOCK_EN
    chk("lock rs_id", bus.rs_id, 0);
`else
    chk("nolock rs_id", bus.rs_id, 1);
`endif
    @(posedge clk); #3;
    chk("end idle", bus.rs_vld, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
# alu_arb

Two-port arbiter and sequencer for the shared `alu` datapath. It accepts ALU operation requests from two requesters (rq0, rq1) over valid/ready handshakes and grants them round-robin. It drives the ALU's `ps_alu_*`/`xb_dt*` inputs and captures the result word and flags one cycle after issue. It returns the captured result on a single response channel with backpressure. It sits between the program sequencer / secondary issue source and the ALU instance.

## Interface
- `DATA_WIDTH`, 16, operand/result width; must match the ALU.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rq0_vld` / `rq1_vld`  in  1  request valid.
- `rq0_rdy` / `rq1_rdy`  out  1  request accepted this cycle (grant).
- `rqN_log`, `rqN_hc[1:0]`, `rqN_sc[2:0]`, `rqN_sat`, `rqN_ci`  in  1/2/3/1/1  opcode fields, same encoding as `ps_alu_*`.
- `rqN_dtx`, `rqN_dty`  in  DATA_WIDTH  operands X, Y.
- `rqN_lock`  in  1  hold grant for the next op (see Configuration).
- `ps_alu_en`  out  1  ALU issue strobe.
- `ps_alu_log`, `ps_alu_hc[1:0]`, `ps_alu_sc[2:0]`, `ps_alu_sat`, `ps_alu_ci`  out  to ALU.
- `xb_dtx`, `xb_dty`  out  DATA_WIDTH  operands to ALU.
- `alu_xb_dt`  in  DATA_WIDTH  ALU result.
- `alu_ps_az`, `alu_ps_an`, `alu_ps_ac`, `alu_ps_av`  in  1  ALU flags.
- `rs_vld`  out  1  response valid.
- `rs_rdy`  in  1  response consumer ready.
- `rs_id`  out  1  requester index of the response.
- `rs_dt`  out  DATA_WIDTH  captured result.
- `rs_flg`  out  4  captured flags `{az,an,ac,av}`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **Issue** (IDLE, or RESP with `rs_rdy`=1) with any `rqN_vld`=1:
  - Select requester by round robin; `rr_ptr` marks the preferred requester.
  - Assert the chosen `rqN_rdy` combinationally.
  - Drive `ps_alu_en`=1 and mux the chosen opcode/operands onto `ps_alu_*`/`xb_dt*`.
  - Register `rqN_ci` into `ci_q` and the id into `id_q`; `rr_ptr` ← other requester.
  - Next state: EXEC.
- **EXEC:**
  - `ps_alu_en`=0. `ps_alu_ci` = `ci_q`, because the ALU samples carry-in combinationally during evaluation.
  - Capture `alu_xb_dt` → `rs_dt` and the four flags → `rs_flg` at the cycle's end.
  - `rs_id` ← `id_q`. Next state: RESP.
- **RESP:**
  - `rs_vld`=1; `rs_dt`/`rs_flg`/`rs_id` hold stable.
  - If `rs_rdy`=0: stay in RESP, grant nothing.
  - If `rs_rdy`=1 and a request is pending: issue in the same cycle (back-to-back), go to EXEC.
  - If `rs_rdy`=1 and no request is pending: go to IDLE.
- Both `rqN_rdy` are 0 in EXEC and in RESP without `rs_rdy`.
- At most one `rqN_rdy` is high per cycle.
- When no op is issuing, `ps_alu_*`/`xb_dt*` are driven to 0 except `ps_alu_ci` (= `ci_q`).
- The ALU's saturation mode is sticky. The arbiter therefore always drives `ps_alu_sat` from the granted request, never a default.
- **Reset** (any state, including mid-EXEC):
  - State → IDLE, `rr_ptr`=0, `ci_q`=0, `id_q`=0.
  - `rs_vld`=0, `rs_dt`=0, `rs_flg`=0, `rs_id`=0.
  - `ps_alu_en`=0, all `rqN_rdy`=0.
  - An in-flight op is discarded and no response is produced.

## Timing
- Grant in cycle T: ALU registers load at the end of T.
- Result is captured at the end of T+1; `rs_vld` rises in T+2.
- Best-case throughput: one op per 2 cycles, with `rs_rdy` tied high and requests continuously valid.
- The requester must hold `rqN_vld` and its fields stable until `rqN_rdy`.
- `rqN_rdy` depends combinationally on `rqN_vld`, `rs_rdy` and state. It never depends on `rqN_rdy` of the other port.
- Simultaneous `rq0_vld`/`rq1_vld` after reset: rq0 is granted first.

## Configuration
- `ALU_ARB_LOCK_EN` defined:
  - If the granted requester has `rqN_lock`=1 at grant, `rr_ptr` is not advanced. If that requester is valid at the next issue opportunity, it wins regardless of the other port.
  - Used for multi-word add/sub-with-carry chains.
- `ALU_ARB_LOCK_EN` undefined: `rqN_lock` ports exist but are ignored; arbitration is strict round robin.

## Structure
- Package `alu_arb_pkg`:
  - state enum (`ARB_IDLE`, `ARB_EXEC`, `ARB_RESP`);
  - flag bit index constants (`FLG_AZ`=3, `FLG_AN`=2, `FLG_AC`=1, `FLG_AV`=0);
  - opcode field widths (`HC_W`=2, `SC_W`=3).
- Sub-module `rr_arb2`: 2-way round-robin grant with pointer and lock input. Contains the pointer register, reset to 0.
- Top level: FSM, operand/opcode mux, result/flag capture registers.

## Test plan
- Single ADD from rq0, then single SUB from rq1:
  - rq0 ADD: log=0, hc=00, sc=000, 0x0003+0x0004 → `rs_vld` in T+2, `rs_dt`=0x0007, `rs_id`=0, `rs_flg`=4'b0000.
  - rq1 SUB: sc=001, 0x0004−0x0004 → `rs_dt`=0x0000, `rs_flg`=4'b1000, `rs_id`=1.
- Saturating add: sat=1, 0x7FFF+0x0001 → `rs_dt`=0x7FFF, av=1. Repeat with sat=0 → 0x8000, an=1, av=1.
- Add-with-carry, ci=1, sc=010, 0x0001+0x0001 → `rs_dt`=0x0003; confirms `ps_alu_ci` is held through EXEC.
- Both requesters valid continuously with `rs_rdy`=1 → grants alternate 0,1,0,1, one grant every 2 cycles.
- Backpressure: `rs_rdy`=0 for 3 cycles in RESP → `rs_vld`, `rs_dt` and `rs_id` stable; no `rqN_rdy`. Release → back-to-back issue in the same cycle.
- Reset asserted during EXEC → next cycle all outputs 0, state IDLE, no response. With `ALU_ARB_LOCK_EN`: rq0_lock=1 and both valid → rq0 granted twice consecutively.
